// File: rtl/serdesphy_tx_lane_ctrl.sv
// Transmit lane controller: chunk assembler, word FIFO, NRZ/Manchester bit shifter and lane FSM.
// Define SERDESPHY_TX_PRBS_EN to add the PRBS7 word source selected by tx_data_sel.
module serdesphy_tx_lane_ctrl #(
  parameter int NIB_W      = 4,
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ERR_LIMIT  = 7
) (
  input  logic             clk_24m,
  input  logic             rst_24m,
  input  logic             tx_en,
  input  logic             tx_idle,
  input  logic             tx_data_sel,
  input  logic             tx_enc_mode,
  input  logic [NIB_W-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             ser_ready,
  input  logic             err_clr,
  output logic             tx_serial_data,
  output logic             tx_serial_valid,
  output logic             tx_idle_pattern,
  output logic             tx_fifo_full,
  output logic             tx_fifo_empty,
  output logic             tx_overflow,
  output logic             tx_underflow,
  output logic             tx_active,
  output logic             tx_error,
  output logic [2:0]       tx_state
);

  localparam int CHUNKS = WORD_W / NIB_W;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SH_W   = 2 * WORD_W;
  localparam int BW     = $clog2(SH_W + 1);
  localparam int EW     = $clog2(ERR_LIMIT + 1);

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [CW-1:0]     asm_cnt_q, asm_cnt_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [EW-1:0]     err_cnt_q, err_cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic              fifo_full, fifo_empty, accept, last_chunk, wr_en, rd_en;
  logic              ovf_ev, unf_ev, load_win, do_load, src_prbs, have_word, active_st;
  logic [WORD_W-1:0] asm_shift, load_word, fifo_word;
  logic [SH_W-1:0]   man_word;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_word  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef SERDESPHY_TX_PRBS_EN
  logic [6:0]        prbs_q, prbs_d;
  logic [WORD_W-1:0] prbs_word;

  assign src_prbs = tx_data_sel;

  // Each output bit is the new feedback bit; first step lands in the word MSB.
  always_comb begin
    logic [6:0] p;
    logic       fb;
    p         = prbs_q;
    fb        = 1'b0;
    prbs_word = '0;
    for (int i = 0; i < WORD_W; i++) begin
      fb                     = p[6] ^ p[5];
      prbs_word[WORD_W-1-i]  = fb;
      p                      = {p[5:0], fb};
    end
    prbs_d = (do_load && src_prbs) ? p : prbs_q;
  end

  always_ff @(posedge clk_24m or posedge rst_24m) begin
    if (rst_24m) prbs_q <= 7'h7F;
    else         prbs_q <= prbs_d;
  end

  assign load_word = src_prbs ? prbs_word : fifo_word;
`else
  logic unused_data_sel;
  assign unused_data_sel = tx_data_sel;
  assign src_prbs        = 1'b0;
  assign load_word       = fifo_word;
`endif

  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_man
    assign man_word[2*gi+1] = load_word[gi];
    assign man_word[2*gi]   = ~load_word[gi];
  end

  assign active_st  = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
  assign accept     = tx_valid && tx_en;
  assign last_chunk = (asm_cnt_q == CW'(CHUNKS - 1));
  assign asm_shift  = (asm_q << NIB_W) | WORD_W'(tx_data);
  assign have_word  = src_prbs || !fifo_empty;
  // Loading is allowed on an idle shifter or on the cycle the final bit leaves.
  assign load_win   = (state_q == ST_ACTIVE) && tx_en && !tx_idle &&
                      ((bits_q == '0) || ((bits_q == BW'(1)) && ser_ready));
  assign do_load    = load_win && have_word;
  assign rd_en      = load_win && !src_prbs && !fifo_empty;
  assign unf_ev     = load_win && !src_prbs && fifo_empty && (bits_q == '0);
  assign wr_en      = accept && last_chunk && (!fifo_full || rd_en);
  assign ovf_ev     = accept && last_chunk && fifo_full && !rd_en;

  always_comb begin
    asm_d     = asm_q;
    asm_cnt_d = asm_cnt_q;
    if (accept) begin
      asm_d     = last_chunk ? '0 : asm_shift;
      asm_cnt_d = last_chunk ? '0 : asm_cnt_q + 1'b1;
    end
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;

    sh_d   = sh_q;
    bits_d = bits_q;
    if (do_load) begin
      sh_d   = tx_enc_mode ? man_word : {load_word, {WORD_W{1'b0}}};
      bits_d = tx_enc_mode ? BW'(SH_W) : BW'(WORD_W);
    end else if (active_st && (bits_q != '0) && ser_ready) begin
      sh_d   = sh_q << 1;
      bits_d = bits_q - 1'b1;
    end

    err_cnt_d = err_cnt_q;
    if (unf_ev && (err_cnt_q != EW'(ERR_LIMIT))) err_cnt_d = err_cnt_q + 1'b1;
    if ((state_q == ST_ERROR) && (err_clr || !tx_en)) err_cnt_d = '0;

    ovf_d = ovf_ev ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    unf_d = unf_ev ? 1'b1 : (err_clr ? 1'b0 : unf_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED: if (tx_en) state_d = ST_IDLE;
      ST_IDLE: begin
        if (!tx_en)                      state_d = ST_DISABLED;
        else if (!tx_idle && have_word)  state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (unf_ev && (err_cnt_d == EW'(ERR_LIMIT))) state_d = ST_ERROR;
        else if (!tx_en || tx_idle)                  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((bits_q == '0) || ((bits_q == BW'(1)) && ser_ready))
          state_d = tx_en ? ST_IDLE : ST_DISABLED;
      end
      ST_ERROR: if (err_clr || !tx_en) state_d = ST_DISABLED;
      default:  state_d = ST_DISABLED;
    endcase
  end

  always_ff @(posedge clk_24m or posedge rst_24m) begin
    if (rst_24m) begin
      state_q   <= ST_DISABLED;
      asm_q     <= '0;
      asm_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      sh_q      <= '0;
      bits_q    <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      asm_q     <= asm_d;
      asm_cnt_q <= asm_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sh_q      <= sh_d;
      bits_q    <= bits_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  always_ff @(posedge clk_24m) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= asm_shift;
  end

  assign tx_ready        = tx_en && !fifo_full;
  assign tx_serial_valid = active_st && (bits_q != '0);
  assign tx_serial_data  = active_st && sh_q[SH_W-1];
  assign tx_idle_pattern = !active_st;
  assign tx_fifo_full    = fifo_full;
  assign tx_fifo_empty   = fifo_empty;
  assign tx_overflow     = ovf_q;
  assign tx_underflow    = unf_q;
  assign tx_active       = active_st;
  assign tx_error        = (state_q == ST_ERROR);
  assign tx_state        = state_q;

endmodule

// File: tb/tb_serdesphy_tx_lane_ctrl.sv
// Bench for serdesphy_tx_lane_ctrl: directed scenarios plus randomized word streams
// compared against a bit-queue model of the encoded output.
module tb_serdesphy_tx_lane_ctrl;
  localparam int NIB_W = 4, WORD_W = 8, FIFO_DEPTH = 8, ERR_LIMIT = 7;

  logic             clk_24m = 1'b0;
  logic             rst_24m = 1'b0;
  logic             tx_en = 1'b0, tx_idle = 1'b0, tx_data_sel = 1'b0, tx_enc_mode = 1'b0;
  logic [NIB_W-1:0] tx_data = '0;
  logic             tx_valid = 1'b0, err_clr = 1'b0;
  logic             ser_ready;
  logic             tx_ready, tx_serial_data, tx_serial_valid, tx_idle_pattern;
  logic             tx_fifo_full, tx_fifo_empty, tx_overflow, tx_underflow;
  logic             tx_active, tx_error;
  logic [2:0]       tx_state;

  logic rnd_rdy = 1'b1;
  bit   rand_rdy = 1'b0;
  bit   rdy_fixed = 1'b1;
  assign ser_ready = rand_rdy ? rnd_rdy : rdy_fixed;

  int n_cmp = 0;
  int n_err = 0;
  bit got_q[$];
  bit exp_q[$];

  always #5 clk_24m = ~clk_24m;

  always @(posedge clk_24m) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk_24m)
    if (!rst_24m && tx_serial_valid && ser_ready) got_q.push_back(tx_serial_data);

  serdesphy_tx_lane_ctrl #(.NIB_W(NIB_W), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH),
                           .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk_24m(clk_24m), .rst_24m(rst_24m), .tx_en(tx_en), .tx_idle(tx_idle),
    .tx_data_sel(tx_data_sel), .tx_enc_mode(tx_enc_mode), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .ser_ready(ser_ready), .err_clr(err_clr),
    .tx_serial_data(tx_serial_data), .tx_serial_valid(tx_serial_valid),
    .tx_idle_pattern(tx_idle_pattern), .tx_fifo_full(tx_fifo_full),
    .tx_fifo_empty(tx_fifo_empty), .tx_overflow(tx_overflow), .tx_underflow(tx_underflow),
    .tx_active(tx_active), .tx_error(tx_error), .tx_state(tx_state)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_24m);
    #1;
  endtask

  task automatic do_reset();
    rst_24m = 1'b1;
    tx_en = 1'b0; tx_idle = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tx_data_sel = 1'b0; tx_enc_mode = 1'b0; err_clr = 1'b0;
    rand_rdy = 1'b0; rdy_fixed = 1'b1;
    tick(); tick();
    rst_24m = 1'b0;
    got_q.delete(); exp_q.delete();
    tick();
  endtask

  task automatic send_word(input logic [7:0] w, input bit gaps);
    for (int c = 0; c < 2; c++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      tx_data = w[7-4*c -: 4];
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
    end
  endtask

  task automatic add_exp(input logic [7:0] w, input bit man);
    for (int i = 7; i >= 0; i--) begin
      if (man) begin
        exp_q.push_back(w[i]);
        exp_q.push_back(!w[i]);
      end else begin
        exp_q.push_back(w[i]);
      end
    end
  endtask

  task automatic wait_size(input int n, input string tag);
    int t = 0;
    while (got_q.size() < n && t < 3000) begin tick(); t++; end
    if (t >= 3000) check_val({tag, "_timeout"}, got_q.size(), n);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int t = 0;
    while (tx_state !== s && t < 200) begin tick(); t++; end
    if (t >= 200) check_val({tag, "_timeout"}, tx_state, s);
  endtask

  task automatic compare_stream(input string tag);
    check_val({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val($sformatf("%s_bit%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  function automatic logic [15:0] pack_got(input int n);
    logic [15:0] v = '0;
    for (int i = 0; i < n && i < got_q.size(); i++) v = {v[14:0], got_q[i]};
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d required finish", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [7:0] words [10];
    int cnt;
    bit hold_d;

    // Asynchronous reset before any clock edge
    #1 rst_24m = 1'b1;
    #2;
    check_val("rst_state", tx_state, 3'd0);
    check_val("rst_idle_pat", tx_idle_pattern, 1'b1);
    check_val("rst_empty", tx_fifo_empty, 1'b1);
    check_val("rst_full", tx_fifo_full, 1'b0);
    check_val("rst_flags", {tx_overflow, tx_underflow, tx_error, tx_active}, 4'd0);
    check_val("rst_serial", {tx_serial_valid, tx_serial_data}, 2'd0);
    check_val("rst_ready", tx_ready, 1'b0);
    do_reset();

    // NRZ 0xA,0x5 -> 10100101 on 8 consecutive cycles
    tx_en = 1'b1; tx_idle = 1'b1; tick();
    send_word(8'hA5, 1'b0);
    tx_idle = 1'b0;
    cnt = 0;
    while (!tx_serial_valid && cnt < 20) begin tick(); cnt++; end
    tx_idle = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      check_val($sformatf("nrz_valid%0d", i), tx_serial_valid, 1'b1);
      check_val($sformatf("nrz_data%0d", i), tx_serial_data, (8'hA5 >> i) & 8'h1);
      tick();
    end
    check_val("nrz_after_valid", tx_serial_valid, 1'b0);
    check_val("nrz_after_state", tx_state, 3'd1);
    $display("test nrz: word 0xA5 sent");

    // Manchester 0x80 with a 3-cycle stall mid-word
    do_reset();
    tx_en = 1'b1; tx_idle = 1'b1; tx_enc_mode = 1'b1; tick();
    send_word(8'h80, 1'b0);
    tx_idle = 1'b0;
    wait_size(5, "man_pre");
    rdy_fixed = 1'b0;
    hold_d = tx_serial_data;
    repeat (3) begin
      tick();
      check_val("man_hold_data", tx_serial_data, hold_d);
      check_val("man_hold_valid", tx_serial_valid, 1'b1);
      check_val("man_hold_cnt", got_q.size(), 5);
    end
    rdy_fixed = 1'b1; tx_idle = 1'b1;
    wait_size(16, "man");
    repeat (4) tick();
    check_val("man_len", got_q.size(), 16);
    check_val("man_bits", pack_got(16), 16'h9555);
    $display("test manchester: word 0x80, %0d bits", got_q.size());

    // Nine words while stalled: eighth fills, ninth overflows and is lost
    do_reset();
    tx_en = 1'b1; tx_idle = 1'b1; tick();
    for (int k = 0; k < 9; k++) begin
      words[k] = 8'($urandom);
      send_word(words[k], 1'b0);
      if (k < 8) add_exp(words[k], 1'b0);
      if (k == 7) begin
        check_val("ovf_full8", tx_fifo_full, 1'b1);
        check_val("ovf_ready8", tx_ready, 1'b0);
        check_val("ovf_flag8", tx_overflow, 1'b0);
      end
    end
    check_val("ovf_flag9", tx_overflow, 1'b1);
    tx_idle = 1'b0;
    wait_size(64, "ovf");
    tx_idle = 1'b1;
    repeat (10) tick();
    compare_stream("ovf_stream");
    $display("test overflow: 9 words offered, %0d bits out", got_q.size());

    // Underflow until ERROR, then err_clr
    do_reset();
    tx_en = 1'b1; tx_idle = 1'b1; tick();
    send_word(8'h3C, 1'b0);
    tx_idle = 1'b0;
    wait_size(8, "unf");
    cnt = 0;
    for (int t = 0; t < 40 && tx_state !== 3'd4; t++) begin
      if (tx_state === 3'd2 && !tx_serial_valid) cnt++;
      tick();
    end
    check_val("unf_attempts", cnt, ERR_LIMIT);
    check_val("unf_state", tx_state, 3'd4);
    check_val("unf_error", tx_error, 1'b1);
    check_val("unf_flag", tx_underflow, 1'b1);
    check_val("unf_valid", tx_serial_valid, 1'b0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check_val("clr_state", tx_state, 3'd0);
    check_val("clr_flags", {tx_error, tx_underflow, tx_overflow}, 3'd0);
    $display("test underflow: %0d attempts before ERROR", cnt);

    // tx_en dropped after 3 bits: word completes via DRAIN
    do_reset();
    tx_en = 1'b1; tx_idle = 1'b1; tick();
    send_word(8'hC3, 1'b0);
    tx_idle = 1'b0;
    wait_size(3, "drain");
    tx_en = 1'b0;
    tick();
    check_val("drain_state", tx_state, 3'd3);
    wait_state(3'd0, "drain_exit");
    check_val("drain_len", got_q.size(), 8);
    check_val("drain_bits", pack_got(8), 16'h00C3);
    check_val("drain_idle_pat", tx_idle_pattern, 1'b1);
    check_val("drain_serial", {tx_serial_valid, tx_serial_data}, 2'd0);
    $display("test drain: %0d bits after tx_en drop", got_q.size());

    // Reset mid-word discards the word and the queued one
    do_reset();
    tx_en = 1'b1; tx_idle = 1'b1; tick();
    send_word(8'hF0, 1'b0);
    send_word(8'h0F, 1'b0);
    tx_idle = 1'b0;
    wait_size(3, "mid_rst");
    rst_24m = 1'b1;
    #1;
    check_val("mid_rst_state", tx_state, 3'd0);
    check_val("mid_rst_empty", tx_fifo_empty, 1'b1);
    check_val("mid_rst_valid", tx_serial_valid, 1'b0);
    tick();
    rst_24m = 1'b0;
    repeat (20) tick();
    check_val("mid_rst_len", got_q.size(), 3);
    check_val("mid_rst_idle", tx_state, 3'd1);
    $display("test reset mid-word: %0d bits before reset", got_q.size());

`ifdef SERDESPHY_TX_PRBS_EN
    // PRBS7 source: first two words from seed 7F
    do_reset();
    tx_en = 1'b1; tx_data_sel = 1'b1; tx_idle = 1'b0;
    wait_size(16, "prbs");
    tx_idle = 1'b1;
    repeat (30) tick();
    begin
      logic [6:0] p = 7'h7F;
      bit b;
      for (int i = 0; i < 16; i++) begin
        b = p[6] ^ p[5];
        exp_q.push_back(b);
        p = {p[5:0], b};
      end
    end
    for (int i = 0; i < 16; i++) check_val($sformatf("prbs_bit%0d", i), got_q[i], exp_q[i]);
    $display("test prbs: %0d bits collected", got_q.size());
`else
    // Without the PRBS source, tx_data_sel must not start the lane
    do_reset();
    tx_en = 1'b1; tx_idle = 1'b0; tx_data_sel = 1'b1;
    repeat (6) tick();
    check_val("nosel_state", tx_state, 3'd1);
    check_val("nosel_valid", tx_serial_valid, 1'b0);
    $display("test data_sel ignored: state %0d", tx_state);
`endif

    // Randomized streams with random backpressure and chunk gaps
    for (int r = 0; r < 10; r++) begin
      int  n;
      bit  man;
      do_reset();
      man = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 10);
      tx_en = 1'b1; tx_idle = 1'b1; tx_enc_mode = man; tick();
      for (int k = 0; k < n; k++) begin
        words[k] = 8'($urandom);
        send_word(words[k], 1'b1);
        if (k < FIFO_DEPTH) add_exp(words[k], man);
      end
      check_val($sformatf("r%0d_full", r), tx_fifo_full, n >= FIFO_DEPTH);
      check_val($sformatf("r%0d_ovf", r), tx_overflow, n > FIFO_DEPTH);
      rand_rdy = 1'b1;
      tx_idle = 1'b0;
      wait_size(exp_q.size(), $sformatf("r%0d", r));
      tx_idle = 1'b1;
      repeat (40) tick();
      rand_rdy = 1'b0;
      compare_stream($sformatf("r%0d", r));
      check_val($sformatf("r%0d_unf", r), tx_underflow, 1'b0);
      check_val($sformatf("r%0d_end_state", r), tx_state, 3'd1);
      $display("round %0d: mode=%0d words=%0d bits=%0d", r, man, n, got_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
